// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register file front end:
// vlmul encoding, sequencer states and the per-channel EMUL calculation.
package vrf_pkg;

  localparam int VREG_NUM       = 32;
  localparam int VRF_ADDR_WIDTH = $clog2(VREG_NUM);

  typedef enum logic [2:0] {
    VLMUL_1    = 3'b000,
    VLMUL_2    = 3'b001,
    VLMUL_4    = 3'b010,
    VLMUL_8    = 3'b011,
    VLMUL_RSVD = 3'b100,
    VLMUL_F8   = 3'b101,
    VLMUL_F4   = 3'b110,
    VLMUL_F2   = 3'b111
  } vlmul_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } seq_state_e;

  // log2 of the register-group size; fractional LMUL (and the reserved code)
  // occupy a single register, widening doubles integral groups only.
  function automatic logic [2:0] emul_log2_f(input logic [2:0] vlmul, input logic widen);
    logic [2:0] e;
    if (vlmul[2]) e = 3'd0;
    else          e = {1'b0, vlmul[1:0]} + {2'b00, widen};
    return e;
  endfunction

endpackage

// File: rtl/vreg_emul_decode.sv
// Per-channel EMUL decode and legality check (reserved vlmul, EMUL of 16,
// base register not aligned to its group size).
module vreg_emul_decode
  import vrf_pkg::*;
#(
  parameter int ADDR_WIDTH = VRF_ADDR_WIDTH
) (
  input  logic [2:0]            vlmul,
  input  logic                  widen,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [2:0]            emul_log2,
  output logic                  illegal
);

  logic [ADDR_WIDTH-1:0] align_mask;

  always_comb begin
    emul_log2  = emul_log2_f(vlmul, widen);
    align_mask = (ADDR_WIDTH'(1) << emul_log2) - ADDR_WIDTH'(1);
    illegal    = (vlmul == VLMUL_RSVD) | (emul_log2 == 3'd4) | (|(base & align_mask));
  end

endmodule

// File: rtl/vreg_group_seq.sv
// Register-group address sequencer: accepts one instruction's channel bases
// and emits one stallable beat per physical register of the widest group.
module vreg_group_seq
  import vrf_pkg::*;
#(
  parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
  parameter int NUM_CH     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   vlmul,
  input  logic [NUM_CH-1:0]            widen,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*ADDR_WIDTH-1:0] addr_out,
  output logic                         addr_start,
  output logic                         addr_end,
  output logic                         err,
  output logic                         idle
);

  seq_state_e                         state, state_n;
  logic [3:0]                         k_p1, k_n;
  logic                               err_p1, err_n;
  logic                               load;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  base_p1;
  logic [NUM_CH-1:0]                  shift_p1, shift_n;
  logic [3:0]                         last_p1;
  logic [NUM_CH-1:0][2:0]             emul_log2;
  logic [NUM_CH-1:0]                  ch_illegal;
  logic [2:0]                         emul_max;
  logic                               illegal;
  logic                               busy;
  logic                               accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vreg_emul_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
      .vlmul     (vlmul),
      .widen     (widen[c]),
      .base      (addr_in[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .emul_log2 (emul_log2[c]),
      .illegal   (ch_illegal[c])
    );
  end

  // Stage 0: cross-channel reduction of the decoded instruction
  always_comb begin
    emul_max = 3'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (emul_log2[c] > emul_max) emul_max = emul_log2[c];
      // Non-widened sources repeat each register twice against a widened group
      shift_n[c] = (|widen) & ~widen[c] & ~vlmul[2];
    end
    illegal = |ch_illegal;
  end

  assign busy       = (state == S_BUSY);
  assign addr_start = busy & (k_p1 == 4'd0);
  assign addr_end   = busy & (k_p1 == last_p1);
  assign in_ready   = rst_n & (~busy | (out_ready & addr_end));
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_n = state;
    k_n     = k_p1;
    err_n   = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal) err_n = 1'b1;
          else begin
            load    = 1'b1;
            state_n = S_BUSY;
            k_n     = 4'd0;
          end
        end
      end
      S_BUSY: begin
        if (out_ready) begin
          if (k_p1 != last_p1) k_n = k_p1 + 4'd1;
          else if (accept && !illegal) begin
            load = 1'b1;
            k_n  = 4'd0;
          end else begin
            err_n   = accept;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k_p1   <= 4'd0;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_n;
      k_p1   <= k_n;
      err_p1 <= err_n;
    end
  end

  // Stage 1: registered group description, only meaningful while busy
  always_ff @(posedge clk) begin
    if (load) begin
      base_p1  <= addr_in;
      shift_p1 <= shift_n;
      last_p1  <= 4'((5'd1 << emul_max) - 5'd1);
    end
  end

  always_comb begin
    addr_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (busy)
        addr_out[c*ADDR_WIDTH +: ADDR_WIDTH] = base_p1[c] + ADDR_WIDTH'(k_p1 >> shift_p1[c]);
    end
  end

  assign out_valid = busy;
  assign err       = err_p1;
  assign idle      = ~busy & ~err_p1;

endmodule

// File: tb/tb_vreg_group_seq.sv
// Scoreboard bench for vreg_group_seq: a reference model predicts every beat
// or error pulse at each accepted instruction; the monitor checks them in order.
module tb_vreg_group_seq;

  localparam int AW = 5;
  localparam int NC = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        vlmul;
  logic [NC-1:0]     widen;
  logic [NC*AW-1:0]  addr_in;
  logic              out_valid;
  logic              out_ready;
  logic [NC*AW-1:0]  addr_out;
  logic              addr_start;
  logic              addr_end;
  logic              err;
  logic              idle;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic             is_err;
    logic             st;
    logic             en;
    logic [NC*AW-1:0] addr;
  } exp_t;

  exp_t sbq[$];

  vreg_group_seq #(.ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vlmul      (vlmul),
    .widen      (widen),
    .addr_in    (addr_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .addr_out   (addr_out),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .err        (err),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: predicted response to the instruction on the inputs now
  task automatic model_push();
    int   emul, lm, n, sh;
    bit   frac, ill;
    logic [AW-1:0] base;
    logic [NC*AW-1:0] a;
    exp_t e;
    frac = vlmul[2];
    ill  = (vlmul == 3'b100);
    n    = 1;
    for (int c = 0; c < NC; c++) begin
      lm   = frac ? 1 : (1 << vlmul[1:0]);
      emul = widen[c] ? (frac ? 1 : 2 * lm) : lm;
      base = addr_in[c*AW +: AW];
      if (emul == 16) ill = 1'b1;
      if ((int'(base) % emul) != 0) ill = 1'b1;
      if (emul > n) n = emul;
    end
    if (ill) begin
      e = '0;
      e.is_err = 1'b1;
      sbq.push_back(e);
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int c = 0; c < NC; c++) begin
          sh = ((|widen) && !widen[c] && !frac) ? 1 : 0;
          a[c*AW +: AW] = AW'((int'(addr_in[c*AW +: AW]) + (k >> sh)) % 32);
        end
        e.is_err = 1'b0;
        e.st     = (k == 0);
        e.en     = (k == n - 1);
        e.addr   = a;
        sbq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("idle_flag", idle, !out_valid && !err);
      if (err) begin
        chk("err_without_valid", out_valid, 0);
        if (sbq.size() == 0) chk("err_unexpected", 0, 1);
        else begin
          e = sbq.pop_front();
          chk("err_expected", err, e.is_err);
        end
      end
      if (out_valid) chk("in_ready_on_end", in_ready, out_ready & addr_end);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("beat_unexpected", 32'(out_valid), 0);
        else begin
          e = sbq.pop_front();
          chk("beat", {14'd0, 1'b0, addr_start, addr_end, addr_out}, {14'd0, e});
        end
      end
      if (in_valid && in_ready) model_push();
    end
  end

  task automatic issue(input logic [2:0] vl, input logic [2:0] w,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    vlmul    = vl;
    widen    = w;
    addr_in  = {a2, a1, a0};
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid && !err) break;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vlmul     = 3'b000;
    widen     = '0;
    addr_in   = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_addr", addr_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // LMUL=4, no widening
    issue(3'b010, 3'b000, 5'd8, 5'd16, 5'd24);
    drain();
    // LMUL=2, vd widened
    issue(3'b001, 3'b001, 5'd4, 5'd2, 5'd6);
    drain();
    // Fractional with widen: single beat
    issue(3'b110, 3'b001, 5'd3, 5'd5, 5'd7);
    drain();
    // EMUL 16 is illegal
    issue(3'b011, 3'b001, 5'd0, 5'd0, 5'd0);
    chk("err_next_cycle", err, 1);
    drain();
    chk("idle_after_err", idle, 1);
    // Misaligned base and reserved vlmul
    issue(3'b010, 3'b000, 5'd8, 5'd6, 5'd16);
    drain();
    issue(3'b100, 3'b000, 5'd0, 5'd0, 5'd0);
    drain();

    // Stall on beat 2 of an LMUL=8 group
    issue(3'b011, 3'b000, 5'd8, 5'd16, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_addr", addr_out, {5'd2, 5'd18, 5'd10});
      chk("stall_hold_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Back-to-back LMUL=2 instructions
    issue(3'b001, 3'b000, 5'd2, 5'd4, 5'd6);
    issue(3'b001, 3'b000, 5'd10, 5'd12, 5'd14);
    drain();

    // Reset in the middle of a group
    issue(3'b001, 3'b000, 5'd20, 5'd22, 5'd24);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_addr", addr_out, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    issue(3'b000, 3'b000, 5'd1, 5'd2, 5'd3);
    drain();

    // Random mix, issued back to back
    for (int i = 0; i < 16; i++) begin
      logic [4:0] m;
      m = (i % 2 == 1) ? 5'h1f : 5'h18;
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)) & m, 5'($urandom_range(0, 31)) & m,
            5'($urandom_range(0, 31)) & m);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vreg_group_seq.md
# vreg_group_seq

Parametrised register-group address sequencer for the vector register file. It accepts one vector instruction's base register numbers for up to `NUM_CH` operand channels (e.g. vd, vs1, vs2) plus LMUL and per-channel widening flags. It then emits one beat per physical register in the group, with a valid/ready handshake that the downstream VRF read/write stage can stall. It sits between instruction decode and the VRF port arbiter. It adds the following on top of the single-channel, non-stalling generation: multiple channels, widening EMUL, alignment/legality checking, and back-to-back issue.

## Interface
- `ADDR_WIDTH`, 5: register number width (32 vector registers).
- `NUM_CH`, 3: number of operand channels sequenced in lock-step.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  instruction presented.
- `in_ready`  out  1  sequencer can accept; transfer when `in_valid & in_ready`.
- `vlmul`  in  3  RVV vlmul encoding: 000/001/010/011 = 1/2/4/8; 101/110/111 = 1/8, 1/4, 1/2; 100 reserved.
- `widen`  in  NUM_CH  per-channel EMUL = 2×LMUL flag.
- `addr_in`  in  NUM_CH×ADDR_WIDTH  base register per channel, channel c at bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `addr_out`  out  NUM_CH×ADDR_WIDTH  per-channel physical register for current beat.
- `addr_start`  out  1  high on first beat of a group (qualified by `out_valid`).
- `addr_end`  out  1  high on last beat of a group (qualified by `out_valid`).
- `err`  out  1  one-cycle pulse: accepted instruction was illegal, no beats emitted.
- `idle`  out  1  no group in flight and no beat pending.

## Operation
- **Per-channel EMUL:**
  - Fractional LMUL counts as 1 register.
  - Widened channel: EMUL = max(1, 2×LMUL).
  - Otherwise EMUL = max(1, LMUL).
- **Beat count:** N = max EMUL over all channels (1, 2, 4, 8 or 16 impossible; see illegal).
- **Beat k (0..N-1), channel c:** `addr_out[c] = addr_in[c] + (k >> s_c)`.
  - s_c = 1 when any channel is widened, this channel is not, and LMUL ≥ 1.
  - s_c = 0 otherwise.
  - Each source register therefore repeats for two beats against a 2×-wide destination.
  - Addition is modulo 2^ADDR_WIDTH; it cannot wrap for legal input.
- **Illegal instruction:** any of the following.
  - vlmul = 100.
  - A widened channel with vlmul = 011 (EMUL 16).
  - Any channel base not a multiple of its EMUL.
- **Illegal response:** still accepted (`in_ready` handshake completes); `err` = 1 the next cycle; no `out_valid`; sequencer returns to IDLE.
- **States:**
  - IDLE: `out_valid` = 0, `in_ready` = 1. A legal accept goes to BUSY with beat counter k = 0 and registered bases, N and shift flags.
  - BUSY: `out_valid` = 1. On `out_ready`: if k ≠ N-1, k++; if k = N-1, then if `in_valid` a new instruction is accepted in the same cycle (legal → BUSY with k = 0; illegal → IDLE plus `err` next cycle), else go to IDLE.
- `in_ready = rst_n & (~out_valid | (out_ready & addr_end))`. This is a combinational path from `out_ready`; the downstream must not combinationally depend on `in_ready`.
- While `out_valid & ~out_ready`: `addr_out`, `addr_start` and `addr_end` are held stable.
- `idle = ~out_valid & ~err`.

## Timing
- **Reset (async assert, sync-safe deassert by upstream synchronizer):**
  - `out_valid`, `addr_out`, `addr_start`, `addr_end` and `err` = 0; `idle` = 1.
  - `in_ready` = 0 while `rst_n` is low, and 1 in the first cycle after release.
- **Reset mid-group:** the group is discarded with no completion beat.
- **Latency:** accept in cycle T → first beat `out_valid` in T+1; the final beat is at T+N with no stalls.
- **Back-to-back:** accept on the last-beat handshake → next group's first beat the very next cycle; 100 % throughput.
- **N = 1:** `addr_start` and `addr_end` are both high on the single beat.
- `err` is a single-cycle pulse in T+1 and is never concurrent with `out_valid`.

## Structure
- **Package `vrf_pkg`:**
  - `vlmul_e` enum (incl. `VLMUL_RSVD`).
  - `emul_log2_f(vlmul, widen)` function returning 0..4.
  - `VREG_NUM` = 32.
  - Shared `ADDR_WIDTH` default.
- **Sub-module `vreg_emul_decode`:** combinational, one instance per channel. Inputs: vlmul, widen, base. Outputs: emul_log2 (3 b) and misaligned/illegal flag. The top module reduces these across channels (max / OR).
- Top module contains the beat counter (4 b), the BUSY flag, registered bases/N/shift flags, and the output adders.

## Test plan
- vlmul = 010, no widen, bases 8/16/24, `out_ready` = 1 → four beats: 8/16/24, 9/17/25, 10/18/26, 11/19/27; start on beat 0, end on beat 3.
- vlmul = 001, widen = 001 (vd only), vd = 4, vs1 = 2, vs2 = 6 → four beats: vd 4,5,6,7; vs1 2,2,3,3; vs2 6,6,7,7.
- vlmul = 110 (1/4) with widen on ch0 → single beat, start = end = 1; then vlmul = 011 with widen → `err` pulse, no `out_valid`, `idle` = 1 after.
- Misaligned: vlmul = 010, base ch1 = 6 → `err` one cycle after accept; vlmul = 100 → `err`.
- Stall: vlmul = 011, `out_ready` low for 3 cycles on beat 2 → `addr_out` held; all 8 beats in order, none duplicated or dropped.
- Back-to-back: two LMUL = 2 instructions, `in_valid` continuous → beats in consecutive cycles, `in_ready` high only on each `addr_end` handshake. Assert `rst_n` low during beat 1 → outputs 0 immediately, `idle` = 1, clean accept after release.
